// File: rtl/pool_engine.sv
// Pooling sequencer: derives output geometry from the POOL fields, walks every window
// through a single-outstanding read port and streams max (or, with POOL_AVG_EN, average) results.
module pool_engine #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int ACC_W  = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  input  logic [15:0]       data_wid,
  input  logic [15:0]       data_hei,
  input  logic [15:0]       data_ch,
  input  logic [15:0]       pool_type,
  input  logic [15:0]       pool_horiz,
  input  logic [15:0]       pool_vert,
  input  logic [15:0]       pool_hstride,
  input  logic [15:0]       pool_vstride,
  output logic [15:0]       output_wid,
  output logic [15:0]       output_hei,
  output logic [15:0]       output_ch,
  output logic [15:0]       out_data_wid,
  output logic [15:0]       out_data_hei,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_gnt,
  input  logic              rd_valid,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr
);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_CALC_W, S_CALC_H, S_FETCH, S_EMIT, S_DONE
  } state_t;

  state_t state;

  logic [15:0] cfg_wid, cfg_hei, cfg_ch, cfg_ph, cfg_pv, cfg_hs, cfg_vs;
  logic [15:0] rem, cnt;
  logic [15:0] c, oy, ox, ky, kx;
  logic        waiting;
  logic [DATA_W-1:0] red;

  logic cfg_bad;
  logic win_last, kx_last, ox_last, oy_last, c_last, first;
  logic [ADDR_W-1:0] in_x, in_y, in_addr, o_addr;
  logic [DATA_W-1:0] red_max, result;
  logic cfg_unused;

  assign cfg_unused = ^{pool_type[15:1], ACC_W[0]};

  assign first    = (kx == 16'd0) && (ky == 16'd0);
  assign kx_last  = (kx == cfg_ph - 16'd1);
  assign win_last = kx_last && (ky == cfg_pv - 16'd1);
  assign ox_last  = (ox == output_wid - 16'd1);
  assign oy_last  = (oy == output_hei - 16'd1);
  assign c_last   = (c == output_ch - 16'd1);

  // Addresses are formed modulo 2^ADDR_W, so truncating every operand first is exact.
  assign in_x    = ADDR_W'(ox) * ADDR_W'(cfg_hs) + ADDR_W'(kx);
  assign in_y    = ADDR_W'(oy) * ADDR_W'(cfg_vs) + ADDR_W'(ky);
  assign in_addr = (ADDR_W'(c) * ADDR_W'(cfg_hei) + in_y) * ADDR_W'(cfg_wid) + in_x;
  assign o_addr  = (ADDR_W'(c) * ADDR_W'(output_hei) + ADDR_W'(oy)) * ADDR_W'(output_wid)
                   + ADDR_W'(ox);

  assign red_max = (first || ($signed(rd_data) > $signed(red))) ? rd_data : red;

`ifdef POOL_AVG_EN
  logic                     cfg_avg;
  logic [4:0]               shamt;
  logic signed [ACC_W-1:0]  acc, acc_nxt;
  logic [31:0]              area;

  function automatic logic [4:0] log2_pow2(input logic [31:0] v);
    log2_pow2 = 5'd0;
    for (int i = 0; i < 32; i++)
      if (v[i]) log2_pow2 = 5'(i);
  endfunction

  assign area    = 32'(pool_horiz) * 32'(pool_vert);
  assign acc_nxt = first ? ACC_W'($signed(rd_data)) : acc + ACC_W'($signed(rd_data));
  assign result  = cfg_avg ? DATA_W'(acc_nxt >>> shamt) : red_max;
`else
  assign result  = red_max;
`endif

  always_comb begin
    cfg_bad = (pool_horiz == 16'd0) || (pool_vert == 16'd0) ||
              (pool_hstride == 16'd0) || (pool_vstride == 16'd0) ||
              (data_ch == 16'd0) || (pool_horiz > data_wid) || (pool_vert > data_hei);
`ifdef POOL_AVG_EN
    if (pool_type[0] && ((area & (area - 32'd1)) != 32'd0)) cfg_bad = 1'b1;
`else
    if (pool_type[0]) cfg_bad = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      cfg_err      <= 1'b0;
      output_wid   <= '0;
      output_hei   <= '0;
      output_ch    <= '0;
      out_data_wid <= '0;
      out_data_hei <= '0;
      rd_req       <= 1'b0;
      rd_addr      <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_addr     <= '0;
      cfg_wid      <= '0;
      cfg_hei      <= '0;
      cfg_ch       <= '0;
      cfg_ph       <= '0;
      cfg_pv       <= '0;
      cfg_hs       <= '0;
      cfg_vs       <= '0;
      rem          <= '0;
      cnt          <= '0;
      c            <= '0;
      oy           <= '0;
      ox           <= '0;
      ky           <= '0;
      kx           <= '0;
      waiting      <= 1'b0;
      red          <= '0;
`ifdef POOL_AVG_EN
      cfg_avg      <= 1'b0;
      shamt        <= '0;
      acc          <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          busy         <= 1'b1;
          cfg_err      <= 1'b0;
          output_wid   <= '0;
          output_hei   <= '0;
          output_ch    <= '0;
          out_data_wid <= '0;
          out_data_hei <= '0;
          state        <= S_CHECK;
        end
        S_CHECK: begin
          cfg_wid <= data_wid;
          cfg_hei <= data_hei;
          cfg_ch  <= data_ch;
          cfg_ph  <= pool_horiz;
          cfg_pv  <= pool_vert;
          cfg_hs  <= pool_hstride;
          cfg_vs  <= pool_vstride;
          rem     <= data_wid - pool_horiz;
          cnt     <= '0;
`ifdef POOL_AVG_EN
          cfg_avg <= pool_type[0];
          shamt   <= log2_pow2(area);
`endif
          if (cfg_bad) begin
            cfg_err <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= S_DONE;
          end else begin
            state   <= S_CALC_W;
          end
        end
        // Quotient by repeated subtraction; cnt ends as floor(span/stride).
        S_CALC_W: if (rem >= cfg_hs) begin
          rem <= rem - cfg_hs;
          cnt <= cnt + 16'd1;
        end else begin
          output_wid <= cnt + 16'd1;
          rem        <= cfg_hei - cfg_pv;
          cnt        <= '0;
          state      <= S_CALC_H;
        end
        S_CALC_H: if (rem >= cfg_vs) begin
          rem <= rem - cfg_vs;
          cnt <= cnt + 16'd1;
        end else begin
          output_hei   <= cnt + 16'd1;
          output_ch    <= cfg_ch;
          out_data_wid <= output_wid;
          out_data_hei <= (cnt + 16'd1) * cfg_ch;
          c            <= '0;
          oy           <= '0;
          ox           <= '0;
          ky           <= '0;
          kx           <= '0;
          waiting      <= 1'b0;
          state        <= S_FETCH;
        end
        S_FETCH: begin
          if (!rd_req && !waiting) begin
            rd_req  <= 1'b1;
            rd_addr <= in_addr;
          end else if (rd_req) begin
            if (rd_gnt) begin
              rd_req  <= 1'b0;
              waiting <= 1'b1;
            end
          end else if (rd_valid) begin
            waiting <= 1'b0;
            red     <= red_max;
`ifdef POOL_AVG_EN
            acc     <= acc_nxt;
`endif
            if (win_last) begin
              kx        <= '0;
              ky        <= '0;
              out_valid <= 1'b1;
              out_data  <= result;
              out_addr  <= o_addr;
              state     <= S_EMIT;
            end else if (kx_last) begin
              kx <= '0;
              ky <= ky + 16'd1;
            end else begin
              kx <= kx + 16'd1;
            end
          end
        end
        S_EMIT: if (out_ready) begin
          out_valid <= 1'b0;
          if (ox_last && oy_last && c_last) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            state <= S_FETCH;
            if (!ox_last) begin
              ox <= ox + 16'd1;
            end else begin
              ox <= '0;
              if (!oy_last) begin
                oy <= oy + 16'd1;
              end else begin
                oy <= '0;
                c  <= c + 16'd1;
              end
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pool_engine.sv
// Randomized scoreboard bench for pool_engine; expectations come from a loop-level pooling model.
module tb_pool_engine;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int ACC_W  = 24;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, done, cfg_err;
  logic [15:0] data_wid = '0, data_hei = '0, data_ch = '0, pool_type = '0;
  logic [15:0] pool_horiz = '0, pool_vert = '0, pool_hstride = '0, pool_vstride = '0;
  logic [15:0] output_wid, output_hei, output_ch, out_data_wid, out_data_hei;
  logic rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic rd_gnt = 1'b0, rd_valid = 1'b0;
  logic [DATA_W-1:0] rd_data = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;

  pool_engine #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .cfg_err(cfg_err),
    .data_wid(data_wid), .data_hei(data_hei), .data_ch(data_ch), .pool_type(pool_type),
    .pool_horiz(pool_horiz), .pool_vert(pool_vert),
    .pool_hstride(pool_hstride), .pool_vstride(pool_vstride),
    .output_wid(output_wid), .output_hei(output_hei), .output_ch(output_ch),
    .out_data_wid(out_data_wid), .out_data_hei(out_data_hei),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] d;
    logic [ADDR_W-1:0] a;
  } out_t;

  out_t              exp_q[$];
  logic [ADDR_W-1:0] rdexp_q[$];
  logic [DATA_W-1:0] mem [0:65535];

  int errors = 0, checks = 0;
  int reads = 0, req_cycles = 0, done_cnt = 0, n_out = 0;
  int ready_mode = 0;
  int pend_cnt = 0;
  logic [DATA_W-1:0] pend_data = '0;

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Reference pooling: direct nested loops over channels, output rows/cols and window taps.
  task automatic model(input int w, h, ch, typ, ph, pv, hs, vs,
                       output bit err, output int ow, output int oh, output int nrd);
    int area;
    err = (ph == 0) || (pv == 0) || (hs == 0) || (vs == 0) || (ch == 0) || (ph > w) || (pv > h);
    area = ph * pv;
`ifdef POOL_AVG_EN
    if (typ[0] && (area == 0 || (area & (area - 1)) != 0)) err = 1;
`else
    if (typ[0]) err = 1;
`endif
    ow = 0; oh = 0; nrd = 0;
    if (err) return;
    ow = (w - ph) / hs + 1;
    oh = (h - pv) / vs + 1;
    for (int ci = 0; ci < ch; ci++)
      for (int y = 0; y < oh; y++)
        for (int x = 0; x < ow; x++) begin
          int best, sum, a, res;
          out_t e;
          best = 0; sum = 0;
          for (int ky = 0; ky < pv; ky++)
            for (int kx = 0; kx < ph; kx++) begin
              int v;
              a = (ci * h + y * vs + ky) * w + x * hs + kx;
              rdexp_q.push_back(ADDR_W'(a));
              nrd++;
              v = int'($signed(mem[ADDR_W'(a)]));
              if ((ky == 0 && kx == 0) || v > best) best = v;
              sum += v;
            end
          res = typ[0] ? (sum >>> $clog2(area)) : best;
          e.d = DATA_W'(res);
          e.a = ADDR_W'((ci * oh + y) * ow + x);
          exp_q.push_back(e);
        end
  endtask

  // Read-port responder: random grant delay, 1..8 cycle latency, occasional stray rd_valid.
  initial begin
    bit req_hold;
    logic [ADDR_W-1:0] held_addr;
    req_hold = 0;
    held_addr = '0;
    forever begin
      @(negedge clk);
      rd_valid = 1'b0;
      rd_gnt = 1'b0;
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          rd_valid = 1'b1;
          rd_data = pend_data;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        rd_valid = 1'b1;
        rd_data = DATA_W'($urandom);
      end
      if (rst_n && rd_req) begin
        req_cycles++;
        if (req_hold) chk("rd_addr_stable", rd_addr, held_addr);
        if (pend_cnt == 0 && !rd_valid && $urandom_range(0, 2) != 0) begin
          rd_gnt = 1'b1;
          pend_data = mem[rd_addr];
          pend_cnt = $urandom_range(1, 8);
          reads++;
          req_hold = 0;
          if (rdexp_q.size() == 0) fail_now("rd_addr unexpected read");
          else chk("rd_addr", rd_addr, rdexp_q.pop_front());
        end else begin
          req_hold = 1;
          held_addr = rd_addr;
        end
      end else begin
        req_hold = 0;
      end
    end
  end

  // Output monitor: drives out_ready and pops the scoreboard for the transfer at the next edge.
  initial begin
    bit hold;
    int stall;
    logic [DATA_W-1:0] hold_d;
    logic [ADDR_W-1:0] hold_a;
    logic rdy;
    hold = 0; stall = 0; hold_d = '0; hold_a = '0;
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (!rst_n) begin
        out_ready = 1'b0;
        hold = 0;
        stall = 0;
        continue;
      end
      case (ready_mode)
        0: rdy = 1'b1;
        1: rdy = ($urandom_range(0, 2) != 0);
        default: rdy = !(out_valid && stall < 5);
      endcase
      if (hold) begin
        chk("hold out_valid", out_valid, 1);
        chk("hold out_data", out_data, hold_d);
        chk("hold out_addr", out_addr, hold_a);
        chk("hold no rd_req", rd_req, 0);
      end
      hold = out_valid && !rdy;
      hold_d = out_data;
      hold_a = out_addr;
      if (out_valid && rdy) begin
        n_out++;
        stall = 0;
        if (exp_q.size() == 0) fail_now("out unexpected result");
        else begin
          out_t e;
          e = exp_q.pop_front();
          chk("out_data", $signed(out_data), $signed(e.d));
          chk("out_addr", out_addr, e.a);
        end
      end else if (out_valid) begin
        stall++;
      end
      out_ready = rdy;
    end
  end

  task automatic set_cfg(input int w, h, ch, typ, ph, pv, hs, vs);
    data_wid = 16'(w); data_hei = 16'(h); data_ch = 16'(ch); pool_type = 16'(typ);
    pool_horiz = 16'(ph); pool_vert = 16'(pv); pool_hstride = 16'(hs); pool_vstride = 16'(vs);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " cfg_err"}, cfg_err, 0);
    chk({tag, " rd_req"}, rd_req, 0);
    chk({tag, " out_valid"}, out_valid, 0);
    chk({tag, " output_wid"}, output_wid, 0);
    chk({tag, " out_data_hei"}, out_data_hei, 0);
    chk({tag, " out_data"}, out_data, 0);
    chk({tag, " out_addr"}, out_addr, 0);
    chk({tag, " rd_addr"}, rd_addr, 0);
  endtask

  task automatic run_layer(input string tag, input int w, h, ch, typ, ph, pv, hs, vs,
                           input int mode, input bit poke);
    bit eerr;
    int eow, eoh, nrd, cyc;
    exp_q.delete();
    rdexp_q.delete();
    model(w, h, ch, typ, ph, pv, hs, vs, eerr, eow, eoh, nrd);
    set_cfg(w, h, ch, typ, ph, pv, hs, vs);
    ready_mode = mode;
    reads = 0; req_cycles = 0; n_out = 0;
    @(negedge clk);
    done_cnt = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, " busy after start"}, busy, 1);
    cyc = 0;
    while (!done && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (poke && cyc == 10 && !done) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc++;
      end
    end
    if (!done) begin
      fail_now({tag, " timeout waiting for done"});
      return;
    end
    chk({tag, " busy at done"}, busy, 0);
    chk({tag, " cfg_err"}, cfg_err, 32'(eerr));
    chk({tag, " output_wid"}, output_wid, eow);
    chk({tag, " output_hei"}, output_hei, eoh);
    chk({tag, " output_ch"}, output_ch, eerr ? 0 : ch);
    chk({tag, " out_data_wid"}, out_data_wid, eow);
    chk({tag, " out_data_hei"}, out_data_hei, eerr ? 0 : eoh * ch);
    @(negedge clk);
    chk({tag, " done pulse width"}, done, 0);
    chk({tag, " done count"}, done_cnt, 1);
    chk({tag, " outputs"}, n_out, eerr ? 0 : eow * eoh * ch);
    chk({tag, " pending outputs"}, exp_q.size(), 0);
    chk({tag, " reads"}, reads, nrd);
    if (eerr) chk({tag, " no rd_req"}, req_cycles, 0);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) mem[i] = DATA_W'(i);
    run_layer("max4x4", 4, 4, 1, 0, 2, 2, 2, 2, 0, 0);

    for (int i = 0; i < 1024; i++) mem[i] = DATA_W'($urandom);
    run_layer("5x5x2", 5, 5, 2, 0, 3, 3, 1, 1, 1, 1);
    run_layer("hstride0", 4, 4, 1, 0, 2, 2, 0, 2, 1, 0);
    run_layer("backpressure", 6, 4, 2, 0, 2, 2, 2, 2, 2, 0);

    mem[0] = -16'sd3; mem[1] = -16'sd1; mem[2] = -16'sd7; mem[3] = -16'sd2;
    run_layer("neg max", 2, 2, 1, 0, 2, 2, 1, 1, 1, 0);
    run_layer("neg avg", 2, 2, 1, 1, 2, 2, 1, 1, 1, 0);
    run_layer("avg 3x3 area", 4, 4, 1, 1, 3, 3, 1, 1, 0, 0);

    for (int t = 0; t < 8; t++) begin
      int w, h, ph, pv;
      for (int i = 0; i < 1024; i++) mem[i] = DATA_W'($urandom);
      w = $urandom_range(1, 7);
      h = $urandom_range(1, 7);
      ph = $urandom_range(1, (w < 4) ? w : 4);
      pv = $urandom_range(1, (h < 4) ? h : 4);
      run_layer("random", w, h, $urandom_range(1, 3), ($urandom_range(0, 3) == 0) ? 1 : 0,
                ph, pv, $urandom_range(1, 3), $urandom_range(1, 3), $urandom_range(0, 2), 0);
    end

    // Abort a layer mid-fetch, then rerun it from scratch.
    begin
      bit eerr;
      int eow, eoh, nrd, cyc;
      for (int i = 0; i < 1024; i++) mem[i] = DATA_W'($urandom);
      exp_q.delete();
      rdexp_q.delete();
      model(5, 5, 2, 0, 3, 3, 1, 1, eerr, eow, eoh, nrd);
      set_cfg(5, 5, 2, 0, 3, 3, 1, 1);
      ready_mode = 1;
      reads = 0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (reads < 7 && cyc < 2000) begin
        @(negedge clk);
        cyc++;
      end
      if (reads < 7) fail_now("midreset timeout waiting for reads");
      rst_n = 1'b0;
      #1;
      check_reset_state("midreset");
      @(negedge clk);
      rst_n = 1'b1;
      run_layer("after reset", 5, 5, 2, 0, 3, 3, 1, 1, 1, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
